counter_load_sched: RTL and testbench
=====================================

COUNTER_LOAD_SCHED -- requirements
Module: counter_load_sched

Interface
REQ-001 Parameter WIDTH, default 8, counter data width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters.
REQ-003 Port clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port req  input  NREQ  per-requester session request, level-sensitive.
REQ-006 Port start_val  input  NREQ*WIDTH  packed start values; requester i at [i*WIDTH +: WIDTH].
REQ-007 Port end_val  input  NREQ*WIDTH  packed terminal values, same packing.
REQ-008 Port gnt  output  NREQ  one-hot grant; high for the owner from LOAD through the RUN exit.
REQ-009 Port done  output  NREQ  one-cycle completion pulse to the owner.
REQ-010 Port busy  output  1  high whenever state is not IDLE.
REQ-011 Port cnt_load  output  1  drives the attached counter's load.
REQ-012 Port cnt_data_in  output  WIDTH  drives the attached counter's data_in.
REQ-013 Port cnt_data_out  input  WIDTH  attached counter's data_out.

Function
REQ-014 The attached counter SHALL load cnt_data_in on a clock edge with cnt_load=1 and otherwise increment by 1 modulo 2^WIDTH.
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: on any req bit set, the block SHALL select one requester round-robin starting at the priority pointer, latch its start_val/end_val, and enter LOAD.
REQ-017 LOAD (exactly one cycle): gnt[owner]=1, cnt_load=1, cnt_data_in=latched start; then RUN.
REQ-018 RUN: cnt_load=0; when cnt_data_out equals the latched end, the block SHALL enter DONE on the next edge.
REQ-019 DONE (one cycle): done[owner]=1, gnt=0; pointer = owner+1 mod NREQ; then IDLE.
REQ-020 Latency SHALL be: done asserted ((end-start) mod 2^WIDTH)+2 cycles after gnt rises.
REQ-021 start equal to end SHALL match in the first RUN cycle (done 2 cycles after gnt).
REQ-022 end below start SHALL complete via counter wrap-around, per REQ-020.
REQ-023 req[owner] low during LOAD or RUN SHALL abort: next cycle IDLE, gnt=0, no done, pointer = owner+1.
REQ-024 Requests from non-owners SHALL be ignored until IDLE; start_val/end_val changes after latching SHALL have no effect.
REQ-025 cnt_data_in SHALL be 0 outside LOAD.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, pointer=0, and gnt, done, busy, cnt_load, cnt_data_in (and timeout, if present) to 0, including mid-session.
REQ-027 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-028 Macro SCHED_TIMEOUT_EN defined: an output port timeout (1 bit) SHALL exist; if RUN lasts 2^WIDTH cycles without a match, timeout pulses one cycle, gnt drops, no done, pointer advances, state returns to IDLE.
REQ-029 Macro SCHED_TIMEOUT_EN undefined: no timeout port; RUN waits indefinitely for a match or abort.

Verification (WIDTH=8, NREQ=4)
REQ-030 req0 held, start=10, end=15 -> gnt[0] rises, cnt_load high 1 cycle with cnt_data_in=10, done[0] pulses 7 cycles after gnt.
REQ-031 req2 held, start=end=0x20 -> done[2] pulses 2 cycles after gnt[2].
REQ-032 req1 held, start=0xFE, end=0x01 -> counter shows FE,FF,00,01; done[1] pulses 5 cycles after gnt[1].
REQ-033 req[3:0] all held, start=end=0 everywhere -> grant order 0,1,2,3,0, one session at a time.
REQ-034 req1 dropped mid-RUN with req2 held -> gnt[1] low next cycle, no done[1], next grant is 2.
REQ-035 rst during RUN -> all outputs 0 next cycle, then req3 and req0 together get grant 0 first. With SCHED_TIMEOUT_EN, cnt_data_out stuck at 0x00 with end=0x05 -> timeout pulses after 256 RUN cycles.

Source files
------------

// File: rtl/counter_load_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : counter_load_sched                                              |
// | Purpose  : Round-robin scheduler that lends an external load/increment     |
// |            counter to one requester at a time. Each session loads a start  |
// |            value and then runs until the counter reaches an end value.     |
// |            Define SCHED_TIMEOUT_EN to add a RUN timeout and its output.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module counter_load_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   start_val,
    input  logic [NREQ*WIDTH-1:0]   end_val,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    cnt_load,
    output logic [WIDTH-1:0]        cnt_data_in,
    input  logic [WIDTH-1:0]        cnt_data_out
`ifdef SCHED_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  r_owner;
    logic [IDXW-1:0]  w_sel;
    logic [IDXW-1:0]  w_owner_inc;
    logic             w_sel_valid;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_end;
    logic [NREQ-1:0]  w_owner_oh;
    logic             w_owner_req;
    logic             w_match;
    logic             w_leave;
    logic             w_expire;

    // Round-robin search: first set request at or after the priority pointer.
    always_comb begin
        w_sel       = r_ptr;
        w_sel_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_sel_valid && req[(int'(r_ptr) + k) % NREQ]) begin
                w_sel       = IDXW'((int'(r_ptr) + k) % NREQ);
                w_sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_owner_oh[i] = (r_owner == IDXW'(i));
        end
    end

    assign w_owner_req = |(req & w_owner_oh);
    assign w_match     = (cnt_data_out == r_end);
    assign w_owner_inc = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);
    assign w_leave     = (r_state != S_IDLE) && (w_next_state == S_IDLE);

`ifdef SCHED_TIMEOUT_EN
    logic [WIDTH-1:0] r_run_cnt;
    logic             r_timeout;

    // r_run_cnt holds the number of completed RUN cycles; all-ones marks the
    // 2^WIDTH-th RUN cycle, where an unmatched session gives up.
    assign w_expire = &r_run_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + WIDTH'(1) : '0;
            r_timeout <= (r_state == S_RUN) && w_owner_req && !w_match && w_expire;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an owner dropping its request takes priority over a match.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel_valid) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = w_owner_req ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (!w_owner_req) begin
                    w_next_state = S_IDLE;
                end else if (w_match) begin
                    w_next_state = S_DONE;
                end else if (w_expire) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Session bookkeeping: owner and operands latched at arbitration, pointer
    // advanced whenever a session ends for any reason.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_start <= '0;
            r_end   <= '0;
        end else begin
            if (r_state == S_IDLE && w_sel_valid) begin
                r_owner <= w_sel;
                r_start <= start_val[int'(w_sel)*WIDTH +: WIDTH];
                r_end   <= end_val[int'(w_sel)*WIDTH +: WIDTH];
            end
            if (w_leave) begin
                r_ptr <= w_owner_inc;
            end
        end
    end

    // Output decode
    always_comb begin
        gnt         = '0;
        done        = '0;
        busy        = (r_state != S_IDLE);
        cnt_load    = 1'b0;
        cnt_data_in = '0;
        case (r_state)
            S_LOAD: begin
                gnt         = w_owner_oh;
                cnt_load    = 1'b1;
                cnt_data_in = r_start;
            end
            S_RUN: begin
                gnt = w_owner_oh;
            end
            S_DONE: begin
                done = w_owner_oh;
            end
            default: begin
                gnt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_load_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_counter_load_sched                                           |
// | Purpose  : Scoreboard bench for counter_load_sched with a model counter;   |
// |            timeout scenario is exercised when SCHED_TIMEOUT_EN is defined. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_counter_load_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    typedef struct {
        int owner;
        int val;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] start_val;
    logic [NREQ*WIDTH-1:0] end_val;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_load;
    logic [WIDTH-1:0]      cnt_data_in;
    logic [WIDTH-1:0]      cnt_data_out;
    logic [WIDTH-1:0]      cnt_model = '0;
    logic                  stuck = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    logic                  timeout;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   g_cycle  = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    exp_t gnt_q[$];
    exp_t done_q[$];
    exp_t e;

    counter_load_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .start_val    (start_val),
        .end_val      (end_val),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .cnt_load     (cnt_load),
        .cnt_data_in  (cnt_data_in),
        .cnt_data_out (cnt_data_out)
`ifdef SCHED_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    always #5 clk = ~clk;

    // Attached counter: load on cnt_load, otherwise increment with wrap.
    always @(posedge clk) begin
        cnt_model <= cnt_load ? cnt_data_in : cnt_model + 8'd1;
    end
    assign cnt_data_out = stuck ? '0 : cnt_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_vals(input int i, input logic [7:0] s, input logic [7:0] t);
        start_val[i*WIDTH +: WIDTH] = s;
        end_val[i*WIDTH +: WIDTH]   = t;
    endtask

    task automatic push_sess(input int owner, input int s, input int lat);
        gnt_q.push_back('{owner: owner, val: s});
        if (lat >= 0) done_q.push_back('{owner: owner, val: lat});
    endtask

    task automatic wait_gnt(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < budget);
        check("wait_gnt", {31'b0, gnt != '0}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < budget);
        check("wait_done", {31'b0, done != '0}, 32'd1);
    endtask

    // Monitor: pops expectations on each grant rise and each done pulse.
    always @(negedge clk) begin
        cyc++;
        if (gnt != '0 && prev_gnt == '0) begin
            g_cycle = cyc;
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                e = gnt_q.pop_front();
                check("gnt_owner", 32'(gnt), 32'(1 << e.owner));
                check("load_pulse", {31'b0, cnt_load}, 32'd1);
                check("load_data", 32'(cnt_data_in), 32'(e.val));
            end
        end
        if (done != '0) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'(done), 32'd0);
            end else begin
                e = done_q.pop_front();
                check("done_owner", 32'(done), 32'(1 << e.owner));
                check("done_latency", 32'(cyc - g_cycle), 32'(e.val));
                check("done_gnt_low", 32'(gnt), 32'd0);
                check("done_data_in_zero", 32'(cnt_data_in), 32'd0);
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        start_val = '0;
        end_val   = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_load", {31'b0, cnt_load}, 32'd0);
        check("rst_data_in", 32'(cnt_data_in), 32'd0);
        rst = 1'b0;

        // Basic session; operand changes after latching must not matter.
        set_vals(0, 8'd10, 8'd15);
        push_sess(0, 10, 7);
        req = 4'b0001;
        wait_gnt(20);
        set_vals(0, 8'd99, 8'd200);
        wait_done(40);
        req = '0;

        // start == end
        set_vals(2, 8'h20, 8'h20);
        push_sess(2, 'h20, 2);
        req = 4'b0100;
        wait_done(40);
        req = '0;

        // wrap-around FE -> 01
        set_vals(1, 8'hFE, 8'h01);
        push_sess(1, 'hFE, 5);
        req = 4'b0010;
        wait_done(40);
        req = '0;

        // Fairness from a fresh reset: 0,1,2,3,0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_vals(i, 8'd0, 8'd0);
        push_sess(0, 0, 2);
        push_sess(1, 0, 2);
        push_sess(2, 0, 2);
        push_sess(3, 0, 2);
        push_sess(0, 0, 2);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_done(40);
        req = '0;

        // Abort by owner 1 while requester 2 waits
        set_vals(1, 8'd0, 8'h80);
        set_vals(2, 8'd3, 8'd4);
        push_sess(1, 0, -1);
        req = 4'b0110;
        wait_gnt(20);
        repeat (5) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        push_sess(2, 3, 3);
        wait_done(40);
        req = '0;

        // Reset mid-RUN, then requester 0 must win over 3
        set_vals(0, 8'd0, 8'hF0);
        push_sess(0, 0, -1);
        req = 4'b0001;
        wait_gnt(20);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_load", {31'b0, cnt_load}, 32'd0);
        check("midrst_data_in", 32'(cnt_data_in), 32'd0);
        rst = 1'b0;
        set_vals(0, 8'd5, 8'd5);
        set_vals(3, 8'd7, 8'd7);
        push_sess(0, 5, 2);
        push_sess(3, 7, 2);
        req = 4'b1001;
        wait_done(40);
        wait_done(40);
        req = '0;

`ifdef SCHED_TIMEOUT_EN
        // Stuck counter never matches: timeout after 256 RUN cycles
        begin
            int n;
            repeat (2) @(negedge clk);
            stuck = 1'b1;
            set_vals(0, 8'd0, 8'd5);
            push_sess(0, 0, -1);
            req = 4'b0001;
            wait_gnt(20);
            n = 0;
            while (!timeout && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("timeout_latency", 32'(n), 32'd257);
            check("timeout_gnt", 32'(gnt), 32'd0);
            check("timeout_done", 32'(done), 32'd0);
            req   = '0;
            stuck = 1'b0;
            @(negedge clk);
            check("timeout_pulse_end", {31'b0, timeout}, 32'd0);
        end
`endif

        repeat (3) @(negedge clk);
        check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
